dac_sample_sequencer: RTL and testbench
=======================================

DAC_SAMPLE_SEQUENCER -- requirements
Module: dac_sample_sequencer

Interface
REQ-001 SHALL have parameter MSBI, default 17, meaning highest sample bit number (sample width MSBI+1, excess 2**MSBI code).
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, meaning the FIFO holds 2**DEPTH_LOG2 samples.
REQ-003 SHALL have parameter DIV_W, default 16, meaning the width of the sample-rate divider.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port s_data, input, MSBI+1 bits: sample to enqueue, excess code.
REQ-007 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-008 SHALL have port s_ready, output, 1 bit: FIFO can accept a sample.
REQ-009 SHALL have port div, input, DIV_W bits: tick period is div+1 clocks.
REQ-010 SHALL have port mute, input, 1 bit: request a fade to midscale.
REQ-011 SHALL have port underrun_clr, input, 1 bit: clears the underrun flag.
REQ-012 SHALL have port dac_in, output, MSBI+1 bits: registered code for the sigma-delta DAC input.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle sample-rate strobe.
REQ-014 SHALL have port underrun, output, 1 bit: sticky flag, set when a tick finds the FIFO empty.
REQ-015 SHALL have port muted, output, 1 bit: high while in the MUTED state.

Function
REQ-016 Divider counter SHALL increment each clock; when counter >= div, tick SHALL be 1 and the counter SHALL load 0; div=0 SHALL give tick every cycle; a div change SHALL take effect through this same comparison.
REQ-017 FIFO SHALL write when s_valid && s_ready; s_ready SHALL be !full; data SHALL be first-in first-out; pointers SHALL wrap modulo depth.
REQ-018 On tick with the FIFO non-empty, the head SHALL pop into the current-sample register cur.
REQ-019 On tick with the FIFO empty, cur SHALL hold its value and underrun SHALL set.
REQ-020 A push and a pop in the same cycle SHALL both occur, leaving occupancy unchanged.
REQ-021 A push into an empty FIFO on a tick cycle SHALL NOT be popped that cycle, and underrun SHALL set.
REQ-022 underrun_clr SHALL clear underrun; a same-cycle set SHALL win over the clear.
REQ-023 A gain register, 9 bits, range 0..256, SHALL change only on tick cycles.
REQ-024 The fade controller SHALL implement four states with the following gain behaviour:
- RUN: gain=256.
- FADE_OUT: gain decrements by 1 per tick.
- MUTED: gain=0.
- FADE_IN: gain increments by 1 per tick.
REQ-025 The fade controller SHALL implement these transitions:
- RUN & mute -> FADE_OUT.
- FADE_OUT & gain reaches 0 -> MUTED.
- FADE_OUT & !mute -> FADE_IN; the reversal starts from the current gain.
- MUTED & !mute -> FADE_IN.
- FADE_IN & mute -> FADE_OUT.
- FADE_IN & gain reaches 256 -> RUN.
REQ-026 Transitions SHALL be evaluated on tick cycles only; mute SHALL be sampled on the tick cycle.
REQ-027 Output arithmetic SHALL be dac_in = mid + ((cur - mid) * gain) >>> 8, where:
- mid = 2**MSBI.
- The difference is signed, MSBI+2 bits.
- The shift is arithmetic.
- No saturation is needed.
- Result: gain=256 SHALL give dac_in == cur exactly; gain=0 SHALL give dac_in == mid exactly.
REQ-028 dac_in SHALL be registered from cur and gain every clock; a sample popped on tick cycle T SHALL first appear on dac_in in cycle T+2.
REQ-029 FIFO flow SHALL be independent of fade state; samples SHALL be consumed at tick rate while MUTED.

Reset
REQ-030 On reset the block SHALL enter this state:
- FIFO empty, s_ready=1.
- Divider counter 0, tick=0.
- cur=mid, gain=0, state MUTED, muted=1.
- dac_in=mid, underrun=0.
REQ-031 Reset asserted mid-fade or mid-transfer SHALL discard FIFO contents and return to the REQ-030 state on the next edge.
REQ-032 After reset with mute=0, FADE_IN SHALL begin on the first tick.

Verification
REQ-033 Scenario: MSBI=17, div=3, mute=0, FIFO kept fed with 0x3FFFF -> tick every 4th clock; after 256 ticks of fade-in, state is RUN and dac_in=0x3FFFF; muted is low throughout the fade.
REQ-034 Scenario: push 4 samples with no tick (div large) -> s_ready=0 after the 4th write; 5th s_valid is not accepted; the next tick pops sample 1 and s_ready returns to 1.
REQ-035 Scenario: FIFO empty at a tick -> underrun=1 and dac_in holds; underrun_clr pulse -> 0; underrun_clr coinciding with a new empty tick -> stays 1.
REQ-036 Scenario: in RUN with cur=0x30000, assert mute for 100 ticks, then deassert -> gain goes 256->156 then climbs back to 256; dac_in=0x20000+((0x10000*g)>>8) at each step; MUTED is never entered.
REQ-037 Scenario: div=0 with a continuous stream of samples -> one pop per clock; sample sequence on dac_in matches the input order with 2-cycle latency.
REQ-038 Scenario: reset asserted mid-FADE_OUT with 3 samples queued -> next cycle FIFO is empty, dac_in=0x20000, muted=1, underrun=0.

Source files
------------

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: FIFO-fed sample sequencer with rate divider and click-free mute fade for a sigma-delta DAC
//   clk, reset          : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : sample input stream (excess 2**MSBI code)
//   div                 : tick period is div+1 clocks
//   mute, underrun_clr  : fade-to-midscale request, sticky underrun clear
//   dac_in, tick, underrun, muted : registered DAC code, rate strobe, status
module dac_sample_sequencer #(
  parameter int MSBI       = 17,
  parameter int DEPTH_LOG2 = 2,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSBI:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             mute,
  input  logic             underrun_clr,
  output logic [MSBI:0]    dac_in,
  output logic             tick,
  output logic             underrun,
  output logic             muted
);
  localparam logic [MSBI:0] MID = {1'b1, {MSBI{1'b0}}};
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  typedef enum logic [1:0] {RUN, FADE_OUT, MUTED, FADE_IN} state_t;
  state_t r_state, w_state_nx;
  logic [DIV_W-1:0] r_cnt;
  logic [DEPTH_LOG2:0] r_wr, r_rd;
  logic [MSBI:0] r_mem [2**DEPTH_LOG2];
  logic [MSBI:0] r_cur;
  logic [8:0] r_gain, w_gain_nx;
  logic w_push, w_pop, w_empty, w_dn, w_up;
  logic signed [MSBI+1:0] w_diff;
  logic signed [MSBI+11:0] w_prod;
  assign tick = !reset && r_cnt >= div;
  assign w_empty = r_wr == r_rd;
  assign s_ready = (r_wr - r_rd) != DEPTH;
  assign w_push = s_valid && s_ready;
  // emptiness is judged before this cycle's push, so a fresh write is never popped on the same tick
  assign w_pop = tick && !w_empty;
  assign muted = r_state == MUTED;
  assign w_diff = $signed({1'b0, r_cur}) - $signed({1'b0, MID});
  assign w_prod = w_diff * $signed({1'b0, r_gain});
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[DEPTH_LOG2-1:0]] <= s_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cur    <= MID;
      underrun <= 1'b0;
      dac_in   <= MID;
    end else begin
      r_cnt    <= tick ? '0 : r_cnt + 1'b1;
      r_wr     <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd     <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cur    <= w_pop ? r_mem[r_rd[DEPTH_LOG2-1:0]] : r_cur;
      underrun <= (tick && w_empty) || (underrun && !underrun_clr);
      dac_in   <= MID + (MSBI+1)'(w_prod >>> 8);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MUTED;
      r_gain  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gain  <= w_gain_nx;
    end
  end
  // gain steps toward the mute target; the state follows from where the step lands
  always_comb begin
    w_state_nx = r_state;
    w_gain_nx  = r_gain;
    w_dn       = mute && r_state != MUTED;
    w_up       = !mute && r_state != RUN;
    if (tick && (w_dn || w_up)) begin
      w_gain_nx  = w_dn ? r_gain - 9'd1 : r_gain + 9'd1;
      w_state_nx = w_gain_nx == 9'd0 ? MUTED : w_gain_nx == 9'd256 ? RUN : w_dn ? FADE_OUT : FADE_IN;
    end
  end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer: randomized check of dac_sample_sequencer against a queue-based reference model
module tb_dac_sample_sequencer;
  localparam longint MID = 64'd1 << 17;
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, mute = 1'b0, underrun_clr = 1'b0;
  logic [17:0] s_data = '0;
  logic [15:0] div = '0;
  logic s_ready, tick, underrun, muted;
  logic [17:0] dac_in;
  int n_chk = 0, n_pass = 0;
  int m_cnt = 0, m_gain = 0;
  longint m_cur = MID;
  bit m_und = 1'b0;
  logic [17:0] m_dac = 18'h20000;
  logic [17:0] q[$];
  dac_sample_sequencer dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .div(div), .mute(mute), .underrun_clr(underrun_clr), .dac_in(dac_in),
    .tick(tick), .underrun(underrun), .muted(muted)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step();
    bit t, emp, push;
    longint d;
    if (reset) begin
      m_cnt = 0; q.delete(); m_cur = MID; m_gain = 0; m_und = 1'b0; m_dac = 18'(MID);
    end else begin
      t = m_cnt >= int'(div);
      emp = q.size() == 0;
      push = s_valid && q.size() < 4;
      d = (m_cur - MID) * m_gain;
      m_dac = 18'(MID + (d >>> 8));
      if (t && !emp) m_cur = longint'(q.pop_front());
      if (push) q.push_back(s_data);
      m_und = (t && emp) || (m_und && !underrun_clr);
      if (t) m_gain = mute ? (m_gain > 0 ? m_gain - 1 : 0) : (m_gain < 256 ? m_gain + 1 : 256);
      m_cnt = t ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    chk("s_ready", 32'(s_ready), 32'(q.size() < 4));
    chk("tick", 32'(tick), 32'(!reset && m_cnt >= int'(div)));
    chk("dac_in", 32'(dac_in), 32'(m_dac));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("muted", 32'(muted), 32'(m_gain == 0));
  endtask
  initial begin
    repeat (3) step();
    chk("rst_dac", 32'(dac_in), 32'h20000);
    chk("rst_muted", 32'(muted), 32'd1);
    chk("rst_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;
    div = 16'd3; s_valid = 1'b1; s_data = 18'h3FFFF;
    repeat (1040) step();
    chk("fadein_dac", 32'(dac_in), 32'h3FFFF);
    chk("fadein_muted", 32'(muted), 32'd0);
    div = 16'd1000;
    repeat (6) begin s_data = 18'($urandom); step(); end
    chk("full_ready", 32'(s_ready), 32'd0);
    div = 16'd0; s_valid = 1'b0;
    step();
    chk("pop_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    repeat (60) begin s_data = 18'($urandom); step(); end
    s_valid = 1'b0;
    repeat (8) step();
    chk("underrun_set", 32'(underrun), 32'd1);
    repeat (4000) begin
      div = 16'($urandom_range(0, 4));
      s_valid = $urandom_range(0, 2) != 0;
      s_data = 18'($urandom);
      underrun_clr = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 699) == 0) mute = !mute;
      reset = $urandom_range(0, 999) == 0;
      step();
    end
    reset = 1'b0; underrun_clr = 1'b0; mute = 1'b0; div = 16'd0;
    repeat (300) begin s_valid = $urandom_range(0, 1) != 0; s_data = 18'($urandom); step(); end
    mute = 1'b1;
    repeat (20) step();
    div = 16'd1000; s_valid = 1'b1;
    repeat (3) begin s_data = 18'($urandom); step(); end
    s_valid = 1'b0; reset = 1'b1;
    step();
    chk("midfade_dac", 32'(dac_in), 32'h20000);
    chk("midfade_muted", 32'(muted), 32'd1);
    chk("midfade_underrun", 32'(underrun), 32'd0);
    chk("midfade_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
